// File: rtl/cpu_bus_bridge.sv
// Round-robin CPU-to-memory-bus bridge: two-ack memory cycle (address, data), then DTACK/ERD to the winner.
// Optional bus-error timeout is enabled with the CPU_BRIDGE_TIMEOUT_EN macro.
module cpu_bus_bridge #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic               clk_en,
  input  logic [NCH-1:0]     dreq,
  input  logic [2*NCH-1:0]   siz,
  input  logic [NCH-1:0]     rw,
  input  logic [NCH-1:0]     is68k,
  input  logic               ba,
  input  logic               ack,
  output logic               mreq,
  output logic               bus_oe,
  output logic [3:0]         w_out,
  output logic               rw_out,
  output logic               justify_out,
  output logic [NCH-1:0]     owner,
  output logic [NCH-1:0]     dtackl,
  output logic [NCH-1:0]     erd,
  output logic [NCH-1:0]     buserr
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  own_idx;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  ptr_next;
  logic [PW-1:0]  grant_idx;
  logic           grant_vld;
  logic           rw_lat;
  logic [3:0]     w_lat;
  logic           err_lat;
  logic           timeout_hit;
  logic [NCH-1:0] qual;
  logic [3:0]     wcode [NCH];

  function automatic logic [3:0] width_code(input logic m68k, input logic [1:0] s);
    if (m68k) return (s == 2'b00) ? 4'b0010 : 4'b0001;
    else      return (s == 2'b00) ? 4'b0100 : {2'b00, s};
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      qual[i]  = dreq[i] & ~ba & (~is68k[i] | (siz[2*i +: 2] != 2'b11));
      wcode[i] = width_code(is68k[i], siz[2*i +: 2]);
    end
  end

  // Round-robin: first scan channels at/after rr_ptr, then wrap to those below it.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!grant_vld && qual[i] && (i >= 32'(rr_ptr))) begin
        grant_vld = 1'b1;
        grant_idx = PW'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!grant_vld && qual[i] && (i < 32'(rr_ptr))) begin
        grant_vld = 1'b1;
        grant_idx = PW'(i);
      end
    end
  end

  always_comb begin
    if (32'(own_idx) == NCH - 1) ptr_next = '0;
    else                         ptr_next = own_idx + 1'b1;
  end

`ifdef CPU_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt;

  assign timeout_hit = ((state == ADDR) || (state == DATA)) && !ack &&
                       ((32'(to_cnt) + 1) >= TIMEOUT_CYC);

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      to_cnt <= '0;
    end else if (clk_en) begin
      if (state == IDLE) begin
        to_cnt <= '0;
      end else if ((state == ADDR) || (state == DATA)) begin
        if (ack) to_cnt <= '0;
        else     to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!resetl) state <= IDLE;
    else if (clk_en) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (grant_vld) state_nx = ADDR;
      ADDR: begin
        if (ack)              state_nx = DATA;
        else if (timeout_hit) state_nx = DONE;
      end
      DATA: begin
        if (ack || timeout_hit) state_nx = DONE;
      end
      DONE: if (!dreq[own_idx]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      own_idx <= '0;
      rr_ptr  <= '0;
      rw_lat  <= 1'b0;
      w_lat   <= '0;
      err_lat <= 1'b0;
    end else if (clk_en) begin
      if ((state == IDLE) && grant_vld) begin
        own_idx <= grant_idx;
        rw_lat  <= rw[grant_idx];
        w_lat   <= wcode[grant_idx];
        err_lat <= 1'b0;
      end
      if (timeout_hit) err_lat <= 1'b1;
      if ((state == DONE) && !dreq[own_idx]) begin
        rr_ptr  <= ptr_next;
        err_lat <= 1'b0;
      end
    end
  end

  always_comb begin
    mreq        = 1'b0;
    bus_oe      = 1'b0;
    w_out       = '0;
    rw_out      = 1'b1;
    justify_out = 1'b0;
    owner       = '0;
    dtackl      = '1;
    erd         = '0;
    buserr      = '0;
    if (state != IDLE) begin
      bus_oe         = 1'b1;
      w_out          = w_lat;
      rw_out         = rw_lat;
      owner[own_idx] = 1'b1;
    end
    if (state == ADDR) mreq = 1'b1;
    if (state == DONE) begin
      if (err_lat) begin
        buserr[own_idx] = 1'b1;
      end else begin
        dtackl[own_idx] = 1'b0;
        erd[own_idx]    = rw_lat;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: per-cycle comparison against a transaction-level model
// plus hand-computed literal checks. Timeout scenario runs when CPU_BRIDGE_TIMEOUT_EN is defined.
module tb_cpu_bus_bridge;

  localparam int unsigned NCH = 2;
`ifdef CPU_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic             sys_clk = 1'b0;
  logic             resetl  = 1'b0;
  logic             clk_en  = 1'b0;
  logic [NCH-1:0]   dreq    = '0;
  logic [2*NCH-1:0] siz     = '0;
  logic [NCH-1:0]   rw      = '0;
  logic [NCH-1:0]   is68k   = '0;
  logic             ba      = 1'b0;
  logic             ack     = 1'b0;
  logic             mreq, bus_oe, rw_out, justify_out;
  logic [3:0]       w_out;
  logic [NCH-1:0]   owner, dtackl, erd, buserr;

  int n_assert = 0;
  int n_fail   = 0;

  cpu_bus_bridge #(.NCH(NCH), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .resetl(resetl), .clk_en(clk_en), .dreq(dreq), .siz(siz),
    .rw(rw), .is68k(is68k), .ba(ba), .ack(ack), .mreq(mreq), .bus_oe(bus_oe),
    .w_out(w_out), .rw_out(rw_out), .justify_out(justify_out), .owner(owner),
    .dtackl(dtackl), .erd(erd), .buserr(buserr)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: a transaction is either absent or in progress with a count of
  // acknowledged phases (0 = address, 1 = data, 2 = finished).
  bit       m_valid = 0;
  bit       m_busy;
  int       m_own, m_phase, m_stall, m_ptr;
  bit       m_err;
  logic     m_rw;
  logic [3:0] m_w;

  function automatic logic [3:0] spec_width(input logic m68k, input logic [1:0] s);
    if (m68k) return (s == 2'b00) ? 4'b0010 : 4'b0001;
    return (s == 2'b00) ? 4'b0100 : {2'b00, s};
  endfunction

  function automatic bit qualified(input int c);
    return dreq[c] && !ba && (!is68k[c] || siz[2*c +: 2] != 2'b11);
  endfunction

  function automatic logic [15:0] model_out();
    logic [NCH-1:0] o, d, e, b;
    logic m, oe, r;
    logic [3:0] w;
    o = '0; d = '1; e = '0; b = '0;
    m = m_busy && (m_phase == 0);
    oe = m_busy;
    w = m_busy ? m_w : 4'b0000;
    r = m_busy ? m_rw : 1'b1;
    if (m_busy) o[m_own] = 1'b1;
    if (m_busy && m_phase == 2) begin
      if (m_err) b[m_own] = 1'b1;
      else begin d[m_own] = 1'b0; e[m_own] = m_rw; end
    end
    return {m, oe, w, r, 1'b0, o, d, e, b};
  endfunction

  always @(negedge sys_clk) begin : compare_and_model
    logic [15:0] act, exp;
    bit found;
    int c;
    act = {mreq, bus_oe, w_out, rw_out, justify_out, owner, dtackl, erd, buserr};
    exp = model_out();
    if (m_valid) begin
      n_assert++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, exp);
      end
    end
    if (!resetl) begin
      m_valid = 1; m_busy = 0; m_own = 0; m_phase = 0; m_stall = 0;
      m_ptr = 0; m_err = 0; m_rw = 1'b0; m_w = 4'b0000;
    end else if (clk_en && m_valid) begin
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (!found && qualified(c)) begin
            found = 1; m_busy = 1; m_own = c; m_phase = 0; m_stall = 0; m_err = 0;
            m_rw = rw[c]; m_w = spec_width(is68k[c], siz[2*c +: 2]);
          end
        end
      end else if (m_phase < 2) begin
        if (ack) begin
          m_phase++; m_stall = 0;
        end else begin
`ifdef CPU_BRIDGE_TIMEOUT_EN
          m_stall++;
          if (m_stall == TO) begin m_phase = 2; m_err = 1; end
`endif
        end
      end else if (!dreq[m_own]) begin
        m_busy = 0; m_err = 0; m_ptr = (m_own + 1) % NCH;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic ce);
    clk_en = ce;
    @(posedge sys_clk);
    #2;
  endtask

  // One bus clock: a sys_clk with clk_en low, then the qualifying edge.
  task automatic tick();
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    resetl = 1'b1;
  endtask

  initial begin
    int e;
    do_reset();
    check("rst_mreq", mreq, 0);
    check("rst_bus_oe", bus_oe, 0);
    check("rst_w_out", w_out, 0);
    check("rst_rw_out", rw_out, 1);
    check("rst_owner", owner, 0);
    check("rst_dtackl", dtackl, 2'b11);
    check("rst_erd_buserr", {erd, buserr}, 0);

    // Native ch0 word read, ack on the 2nd clk_en of each phase
    rw = 2'b01; siz = 4'b0000; is68k = 2'b00; dreq = 2'b01; ack = 0;
    tick();
    check("t1_addr_mreq", mreq, 1);
    check("t1_w_out", w_out, 4'b0100);
    check("t1_owner", owner, 2'b01);
    tick();
    check("t1_addr_hold", mreq, 1);
    ack = 1; tick();
    check("t1_data_mreq", {mreq, bus_oe}, 2'b01);
    ack = 0; tick();
    ack = 1; tick();
    check("t1_done_dtackl", dtackl, 2'b10);
    check("t1_done_erd", erd, 2'b01);
    ack = 0; tick();
    check("t1_done_hold", dtackl, 2'b10);
    dreq = 2'b00; tick();
    check("t1_idle_owner", owner, 0);
    check("t1_idle_dtackl", dtackl, 2'b11);

    // Both channels requesting, ack always high: 0,1,0,1 every 4 clk_en
    do_reset();
    siz = 4'b1100; rw = 2'b01; dreq = 2'b11; ack = 1;
    for (int g = 0; g < 4; g++) begin
      e = g % 2;
      tick();
      check("t2_grant_owner", owner, 32'(1) << e);
      check("t2_grant_w", w_out, (e == 1) ? 4'b0011 : 4'b0100);
      tick(); tick();
      check("t2_done_dtackl", dtackl, ~(32'(1) << e) & 32'h3);
      dreq[e] = 1'b0; tick();
      check("t2_released", owner, 0);
      dreq[e] = 1'b1;
    end
    dreq = 2'b00; ack = 0;

    // dreq dropped during ADDR: DONE lasts one clk_en
    dreq = 2'b01; tick();
    dreq = 2'b00; ack = 1; tick(); tick();
    check("t3_done_once", dtackl, 2'b10);
    ack = 0; tick();
    check("t3_done_exit", {owner, dtackl}, 4'b0011);

    // 68k ch1 with both strobes inactive: never granted
    is68k = 2'b10; siz = 4'b1100; dreq = 2'b10; tick(); tick();
    check("t4_no_grant", {owner, mreq}, 0);

    // 68k ch1 byte write, ack during clk_en low is ignored
    siz = 4'b1000; rw = 2'b00; tick();
    check("t5_w_out", w_out, 4'b0001);
    check("t5_rw_out", rw_out, 0);
    check("t5_owner", owner, 2'b10);
    ack = 1; cyc(1'b0); ack = 0; cyc(1'b1);
    check("t5_ack_ignored", mreq, 1);
    ack = 1; tick(); tick();
    check("t5_done", {dtackl, erd}, 4'b0100);
    dreq = 2'b00; ack = 0; tick();

    // ba blocks new grant but not a cycle in flight
    is68k = 2'b00; siz = 4'b0000; rw = 2'b01; ba = 1; dreq = 2'b01;
    tick(); tick();
    check("t6_ba_block", {owner, bus_oe}, 0);
    ba = 0; tick();
    check("t6_grant", owner, 2'b01);
    ack = 1; tick();
    ba = 1; tick();
    check("t6_ba_done", dtackl, 2'b10);
    dreq = 2'b00; ack = 0; tick();
    ba = 0;

    // Reset during DATA aborts; channel 0 wins first afterwards
    dreq = 2'b01; ack = 1; tick(); tick();
    check("t7_in_data", {mreq, bus_oe}, 2'b01);
    ack = 0;
    resetl = 1'b0; cyc(1'b0); resetl = 1'b1;
    check("t7_abort", {mreq, bus_oe, dtackl, owner}, 6'b001100);
    dreq = 2'b11; tick();
    check("t7_ch0_first", owner, 2'b01);
    ack = 1; tick(); tick();
    dreq = 2'b00; tick();
    ack = 0;

`ifdef CPU_BRIDGE_TIMEOUT_EN
    // No ack: bus error after TO clk_en periods in ADDR
    dreq = 2'b01; tick();
    repeat (TO - 1) tick();
    check("t8_pre_timeout", {mreq, buserr}, 3'b100);
    tick();
    check("t8_buserr", buserr, 2'b01);
    check("t8_dtackl", dtackl, 2'b11);
    check("t8_erd", erd, 0);
    tick();
    check("t8_hold", buserr, 2'b01);
    dreq = 2'b00; tick();
    check("t8_clear", {buserr, bus_oe}, 0);
`endif

    repeat (3) cyc(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

Multi-channel CPU-to-memory-bus bridge. It arbitrates round-robin among NCH CPU-style requesters, some 68000-type and some native 32-bit. It runs a two-acknowledge memory cycle (address phase, then data phase) on the shared internal bus. It returns a per-channel DTACK and read-enable to the winning requester. It sits between the CPU/DSP/external bus ports and the memory controller.

## Interface
- NCH, 2: number of requester channels (1..8).
- TIMEOUT_CYC, 255: clk_en-qualified cycles without ack before a bus error is raised (only used with CPU_BRIDGE_TIMEOUT_EN).
- sys_clk  in  1  system clock; all state changes on its rising edge.
- resetl  in  1  reset, synchronous, active-low; acts on any sys_clk edge, independent of clk_en.
- clk_en  in  1  one-sys_clk pulse marking a bus clock edge; state advances only when high.
- dreq  in  NCH  per-channel cycle request, level.
- siz  in  2*NCH  per-channel size; for 68k channels, bits are active-low {UDS,LDS}.
- rw  in  NCH  per-channel direction, 1 = read.
- is68k  in  NCH  channel uses 68k strobe encoding.
- ba  in  1  bus granted to external master; blocks new grants.
- ack  in  1  memory controller phase acknowledge.
- mreq  out  1  memory request.
- bus_oe  out  1  bridge drives mreq/w_out/rw_out/justify_out.
- w_out  out  4  transfer width code.
- rw_out  out  1  latched direction.
- justify_out  out  1  always 0.
- owner  out  NCH  one-hot current owner; all-zero in IDLE.
- dtackl  out  NCH  per-channel data acknowledge, active-low.
- erd  out  NCH  per-channel read-data enable.
- buserr  out  NCH  per-channel bus error (0 when macro absent).

## Operation
- States: IDLE, ADDR, DATA, DONE. Transitions are evaluated only when clk_en=1.
- Qualified request for channel i: dreq[i] & ~ba & (~is68k[i] | siz[i] != 2'b11).
- IDLE: if any channel is qualified, grant the first qualified channel at or after rr_ptr (wrapping modulo NCH). Latch the owner, rw, and w, then go to ADDR.
- Width code:
  - 68k channel: siz==2'b00 gives w=4'b0010 (word); otherwise 4'b0001 (byte).
  - Native channel: siz==2'b00 gives w=4'b0100; otherwise {2'b00,siz}.
- ADDR: mreq=1. On ack, go to DATA; otherwise hold.
- DATA: mreq=0. On ack, go to DONE; otherwise hold.
- DONE: dtackl[owner]=0, and erd[owner]=latched rw. Hold while dreq[owner]=1. When dreq[owner]=0, go to IDLE and set rr_ptr = owner+1 (mod NCH).
- bus_oe=1 in ADDR, DATA, and DONE. w_out and rw_out show latched values while bus_oe=1, and 0 and 1 otherwise.
- If dreq[owner] drops during ADDR or DATA, the cycle still completes. DONE then lasts exactly one clk_en period.
- ba affects only grants in IDLE. A cycle in flight completes normally.
- Outputs of non-owner channels: dtackl=1, erd=0, buserr=0.

## Timing
- All outputs are decoded from registered state and change one sys_clk after the clk_en edge that caused the transition.
- Minimum cycle is 4 clk_en periods: IDLE→ADDR, ADDR→DATA, DATA→DONE, DONE→IDLE. Back-to-back grants therefore start every 4th clk_en at best.
- ack sampled while clk_en=0 is ignored. ack held high advances exactly one state per clk_en.
- Simultaneous requests: rr_ptr decides. After reset rr_ptr=0, so channel 0 wins first.
- Reset values: state IDLE, rr_ptr 0, mreq 0, bus_oe 0, w_out 0, rw_out 1, justify_out 0, owner 0, dtackl all 1, erd 0, buserr 0, timeout counter 0.
- resetl low mid-cycle aborts immediately to the reset values, with no completion on the memory side.

## Configuration
- CPU_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on entry to ADDR and on ack. It increments on each clk_en spent in ADDR or DATA without ack.
  - When it reaches TIMEOUT_CYC, the bridge goes to DONE with buserr[owner]=1 and dtackl[owner]=1, and erd stays 0.
  - Exit from DONE follows the normal dreq-drop rule, and buserr clears on that exit.
- Macro absent: no counter; ADDR and DATA wait for ack indefinitely; buserr is tied to 0.

## Test plan
- NCH=2, native ch0, siz=2'b00, rw=1, ack on the 2nd clk_en in ADDR and DATA:
  - Expected: mreq high 2 clk_en periods; w_out=4'b0100; then dtackl[0]=0 and erd[0]=1 until dreq[0] drops; then IDLE with owner=0.
- ch0 and ch1 both request continuously, ack always 1:
  - Expected: grants alternate 0,1,0,1 and each grant lasts 4 clk_en periods.
- 68k ch1, siz=2'b11: no grant.
- 68k ch1, siz=2'b10:
  - Expected: grant with w_out=4'b0001 and rw_out equal to rw[1].
- ba=1 while ch0 requests: no grant. Assert ba during DATA: the cycle still completes with dtackl[0]=0.
- resetl=0 for 1 sys_clk while in DATA:
  - Expected: next cycle mreq=0, bus_oe=0, dtackl=all 1, owner=0; after release, ch0 is granted first.
- CPU_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=8, ack never asserted:
  - Expected: after 8 clk_en periods in ADDR, buserr[0]=1 and dtackl[0]=1; buserr clears after dreq[0] falls.
